seq_alu_md: RTL
===============

Name: seq_alu_md

Overview:
Parametrised, registered successor to the single-cycle datapath ALU. It adds an iterative multiply/divide unit with HI/LO registers and a start/busy/done handshake. It extends the op set with xor/sll/slt/sltu and reports signed overflow. It sits in the EX stage; the pipeline stalls on busy.

Parameters:
WIDTH, 32, operand/result width in bits (power of 2, >= 8)
SHAMT_W, derived localparam = clog2(WIDTH), shift-amount bits taken from B

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request; sampled only when busy=0
op  in  4  operation code (encoding below)
A  in  WIDTH  operand A
B  in  WIDTH  operand B
C  out  WIDTH  registered single-cycle result
ov  out  1  registered signed overflow of add/sub, else 0
hi  out  WIDTH  HI register (product high / remainder)
lo  out  WIDTH  LO register (product low / quotient)
busy  out  1  iterative op in progress
done  out  1  one-cycle pulse, result valid

Behaviour:
- Reset: C=0, ov=0, hi=0, lo=0, busy=0, done=0, FSM=IDLE. Reset mid-operation aborts the operation. The next cycle shows busy=0 and done=0, and HI/LO are cleared.
- Op encoding:
  - 0 add, 1 sub, 2 and, 3 or, 4 srl, 5 sra, 6 sll, 7 xor
  - 8 slt (signed, C=1/0), 9 sltu
  - 10 mult, 11 multu, 12 div, 13 divu
  - 14, 15 reserved: treated as op 0–9 class with C=0, ov=0
- Shifts use B[SHAMT_W-1:0] only. sra replicates A[WIDTH-1].
- ov=1 only for add/sub signed overflow. Results wrap modulo 2^WIDTH.
- Single-cycle class (0–9, 14, 15): start accepted at edge N; C/ov valid and done=1 during cycle N+1. busy stays 0. hi/lo are untouched.
- Iterative class (10–13), states IDLE -> RUN -> DONE -> IDLE:
  - Accepting start in IDLE latches A, B, op and moves to RUN; the counter loads WIDTH.
  - RUN: busy=1 for exactly WIDTH cycles, one shift-add (mult) or one restoring-subtract (div) step per cycle on magnitudes.
  - DONE: one cycle; busy=0, done=1, hi/lo updated on entry; the FSM returns to IDLE. Start is accepted in DONE, so back-to-back ops are possible.
  - Total: start at edge N, done high in cycle N+WIDTH+1.
  - C and ov hold their previous values during iterative ops.
- Sign handling:
  - mult: signed 2*WIDTH product, {hi,lo}.
  - multu: unsigned product.
  - div: quotient truncates toward zero; remainder takes the sign of the dividend.
  - divu: unsigned.
- Division by zero: lo = all ones, hi = A. Signed case identical. Full latency.
- Signed MIN / -1: lo=MIN, hi=0, no fault.
- start while busy=1 is ignored with no side effects. Operand changes during RUN have no effect.
- Outputs hold their last values when idle.

Optional Feature:
SEQ_ALU_MD_DIV0_FLAG_EN:
- When defined: adds output port div0 (1 bit). For div/divu with B=0, the unit skips RUN and goes directly to DONE, so done is high in cycle N+1. div0=1 with done and hi/lo are left unchanged. div0=0 otherwise; reset value 0.
- When undefined: no div0 port; divide-by-zero follows the full-latency defined result above.

Test Plan:
1. add A=0x7FFFFFFF B=1 -> cycle N+1: C=0x80000000, ov=1, done=1, busy=0 throughout.
2. sra A=0x80000000 B=0x00000024 (shamt 4) -> C=0xF8000000; sll A=1 B=31 -> C=0x80000000; slt A=0xFFFFFFFF B=1 -> C=1; sltu same -> C=0.
3. mult A=0xFFFFFFFD (-3) B=5 -> busy high 32 cycles, done in cycle N+33 with hi=0xFFFFFFFF, lo=0xFFFFFFF1; multu same operands -> hi=0x00000004, lo=0xFFFFFFF1.
4. div A=0xFFFFFFF9 (-7) B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu A=7 B=0 -> lo=0xFFFFFFFF, hi=7 after full latency (macro off); div A=0x80000000 B=0xFFFFFFFF -> lo=0x80000000, hi=0.
5. Pulse start with op=add during RUN cycle 5 of a mult -> ignored, C unchanged, mult result correct. Start a new divu in the DONE cycle -> accepted, busy high next cycle.
6. Assert reset in RUN cycle 10 of a divu -> next cycle busy=0, done=0, hi=lo=C=0, no done pulse afterwards until a new start.

Source files
------------

// File: rtl/seq_alu_md.sv
// seq_alu_md: registered ALU with an iterative shift-add multiplier / restoring divider feeding HI/LO.
// Optional macro SEQ_ALU_MD_DIV0_FLAG_EN adds a div0 port and early completion of divide-by-zero.
module seq_alu_md #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] C,
   output logic             ov,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
`ifdef SEQ_ALU_MD_DIV0_FLAG_EN
   ,
   output logic             div0
`endif
);
   localparam int SHAMT_W = $clog2(WIDTH);
   localparam int CNT_W   = SHAMT_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
   state_t state_reg, state_next;

   logic [WIDTH-1:0] c_reg, hi_reg, lo_reg;
   logic [WIDTH-1:0] acc_reg, q_reg, mag_b_reg, a_reg;
   logic             ov_reg, sc_done_reg;
   logic             div_mode_reg, neg_q_reg, neg_r_reg, b_zero_reg;
   logic [CNT_W-1:0] cnt_reg;

   logic accept, is_iter, skip_run;
   assign accept  = start && (state_reg != S_RUN);
   assign is_iter = (op >= 4'd10) && (op <= 4'd13);
`ifdef SEQ_ALU_MD_DIV0_FLAG_EN
   assign skip_run = ((op == 4'd12) || (op == 4'd13)) && (B == '0);
`else
   assign skip_run = 1'b0;
`endif

   // Single-cycle ALU
   logic [SHAMT_W-1:0] shamt;
   logic [WIDTH-1:0]   sum, diff, alu_c;
   logic               alu_ov;
   assign shamt = B[SHAMT_W-1:0];
   assign sum   = A + B;
   assign diff  = A - B;

   always_comb begin
      alu_c  = '0;
      alu_ov = 1'b0;
      case (op)
         4'd0: begin
            alu_c  = sum;
            alu_ov = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
         end
         4'd1: begin
            alu_c  = diff;
            alu_ov = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
         end
         4'd2: alu_c = A & B;
         4'd3: alu_c = A | B;
         4'd4: alu_c = A >> shamt;
         4'd5: alu_c = $unsigned($signed(A) >>> shamt);
         4'd6: alu_c = A << shamt;
         4'd7: alu_c = A ^ B;
         4'd8: alu_c = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
         4'd9: alu_c = {{(WIDTH-1){1'b0}}, (A < B)};
         default: ;
      endcase
   end

   // Operands are reduced to magnitudes; the sign is reapplied when the last step retires
   logic             sgn_op, a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;
   assign sgn_op = (op == 4'd10) || (op == 4'd12);
   assign a_neg  = sgn_op && A[WIDTH-1];
   assign b_neg  = sgn_op && B[WIDTH-1];
   assign a_mag  = a_neg ? -A : A;
   assign b_mag  = b_neg ? -B : B;

   logic [WIDTH:0]   mul_sum, div_shift, div_trial;
   logic [WIDTH-1:0] step_acc, step_q;
   always_comb begin
      mul_sum   = {1'b0, acc_reg} + {1'b0, ({WIDTH{q_reg[0]}} & mag_b_reg)};
      div_shift = {acc_reg, q_reg[WIDTH-1]};
      div_trial = div_shift - {1'b0, mag_b_reg};
      if (div_mode_reg) begin
         if (!div_trial[WIDTH]) begin
            step_acc = div_trial[WIDTH-1:0];
            step_q   = {q_reg[WIDTH-2:0], 1'b1};
         end else begin
            step_acc = div_shift[WIDTH-1:0];
            step_q   = {q_reg[WIDTH-2:0], 1'b0};
         end
      end else begin
         step_acc = mul_sum[WIDTH:1];
         step_q   = {mul_sum[0], q_reg[WIDTH-1:1]};
      end
   end

   logic [2*WIDTH-1:0] prod_mag, prod;
   logic [WIDTH-1:0]   quo, rem, fin_hi, fin_lo;
   always_comb begin
      prod_mag = {step_acc, step_q};
      prod     = neg_q_reg ? -prod_mag : prod_mag;
      quo      = neg_q_reg ? -step_q : step_q;
      rem      = neg_r_reg ? -step_acc : step_acc;
      if (!div_mode_reg) begin
         fin_hi = prod[2*WIDTH-1:WIDTH];
         fin_lo = prod[WIDTH-1:0];
      end else if (b_zero_reg) begin
         fin_hi = a_reg;
         fin_lo = '1;
      end else begin
         fin_hi = rem;
         fin_lo = quo;
      end
   end

   // FSM: state register
   always_ff @(posedge clk) begin
      if (reset) state_reg <= S_IDLE;
      else       state_reg <= state_next;
   end

   // FSM: next state
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE, S_DONE: begin
            state_next = S_IDLE;
            if (accept && is_iter) state_next = skip_run ? S_DONE : S_RUN;
         end
         S_RUN:   if (cnt_reg == CNT_W'(1)) state_next = S_DONE;
         default: state_next = S_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      busy = (state_reg == S_RUN);
      done = (state_reg == S_DONE) || sc_done_reg;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         c_reg        <= '0;
         ov_reg       <= 1'b0;
         hi_reg       <= '0;
         lo_reg       <= '0;
         sc_done_reg  <= 1'b0;
         acc_reg      <= '0;
         q_reg        <= '0;
         mag_b_reg    <= '0;
         a_reg        <= '0;
         cnt_reg      <= '0;
         div_mode_reg <= 1'b0;
         neg_q_reg    <= 1'b0;
         neg_r_reg    <= 1'b0;
         b_zero_reg   <= 1'b0;
      end else begin
         sc_done_reg <= 1'b0;
         if (accept && !is_iter) begin
            c_reg       <= alu_c;
            ov_reg      <= alu_ov;
            sc_done_reg <= 1'b1;
         end
         if (accept && is_iter && !skip_run) begin
            acc_reg      <= '0;
            q_reg        <= a_mag;
            mag_b_reg    <= b_mag;
            a_reg        <= A;
            div_mode_reg <= op[2];
            neg_q_reg    <= a_neg ^ b_neg;
            neg_r_reg    <= a_neg;
            b_zero_reg   <= (B == '0);
            cnt_reg      <= CNT_W'(WIDTH);
         end
         if (state_reg == S_RUN) begin
            acc_reg <= step_acc;
            q_reg   <= step_q;
            cnt_reg <= cnt_reg - 1'b1;
            if (cnt_reg == CNT_W'(1)) begin
               hi_reg <= fin_hi;
               lo_reg <= fin_lo;
            end
         end
      end
   end

`ifdef SEQ_ALU_MD_DIV0_FLAG_EN
   logic div0_reg;
   always_ff @(posedge clk) begin
      if (reset) div0_reg <= 1'b0;
      else       div0_reg <= accept && skip_run;
   end
   assign div0 = div0_reg;
`endif

   assign C  = c_reg;
   assign ov = ov_reg;
   assign hi = hi_reg;
   assign lo = lo_reg;
endmodule
